// File: rtl/req_latch_8.sv
// rtl/req_latch_8.sv - sticky, maskable eight-line request capture ahead of an 8-to-3 priority encoder
//
// Purpose:
//   Converts raw request lines into sticky pending bits. Each pending bit is gated by a
//   mask and driven to its own output, one output per encoder input. Software clears a
//   pending bit by acknowledging its index. A sticky overrun flag records any request that
//   arrived while its bit was still pending.
//
// Parameters:
//   EDGE_MODE  1 = a rising edge of req[n] sets pending[n]
//              0 = req[n] high sets pending[n] on every cycle
//
// Ports:
//   Clk      in   1   system clock, rising-edge active
//   Reset    in   1   asynchronous, active-high reset
//   req      in   8   raw request lines, synchronous to Clk
//   mask_wr  in   1   load mask_in into the mask register
//   mask_in  in   8   new mask value, 1 = enabled
//   ack      in   1   acknowledge strobe
//   ack_idx  in   3   index of the pending bit to clear while ack = 1
//   clr_ovr  in   1   clear the overrun flag
//   p7..p0   out  1   masked pending bits; pn drives encoder input n
//   any      out  1   OR of p7..p0; qualifies the encoder code
//   ovr      out  1   sticky overrun flag

module req_latch_8 #(
    parameter int EDGE_MODE = 1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] req,
    input  logic       mask_wr,
    input  logic [7:0] mask_in,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       clr_ovr,
    output logic       p7,
    output logic       p6,
    output logic       p5,
    output logic       p4,
    output logic       p3,
    output logic       p2,
    output logic       p1,
    output logic       p0,
    output logic       any,
    output logic       ovr
);

    logic [7:0] r_prev;
    logic [7:0] r_pending;
    logic [7:0] r_mask;
    logic       r_ovr;

    logic [7:0] w_event;
    logic [7:0] w_ackvec;
    logic [7:0] w_pending_nxt;
    logic       w_ovr_set;
    logic [7:0] w_out;

    // prev resets to 0, so in edge mode a request held high through reset is seen
    // as a rising edge at the first clock after reset is released.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            assign w_event = req & ~r_prev;
        end else begin : g_level
            assign w_event = req;
        end
    endgenerate

    always_comb begin
        w_ackvec = 8'h00;
        if (ack) begin
            w_ackvec[ack_idx] = 1'b1;
        end
    end

    // The event term is OR-ed after the acknowledge clear, so a new event on the bit
    // being acknowledged survives. Acknowledging a clear bit is harmless.
    assign w_pending_nxt = (r_pending & ~w_ackvec) | w_event;

    // An event on a bit that is already pending is only lost if that bit is not being
    // acknowledged in the same cycle; the same-cycle ack case re-pends cleanly.
    assign w_ovr_set = |(w_event & r_pending & ~w_ackvec);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_prev    <= 8'h00;
            r_pending <= 8'h00;
            r_mask    <= 8'hFF;
            r_ovr     <= 1'b0;
        end else begin
            r_prev    <= req;
            r_pending <= w_pending_nxt;
            if (mask_wr) begin
                r_mask <= mask_in;
            end
            // Set takes priority over clear.
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

    // Outputs depend on registers only; masking hides a bit without clearing it.
    assign w_out = r_pending & r_mask;

    assign p7  = w_out[7];
    assign p6  = w_out[6];
    assign p5  = w_out[5];
    assign p4  = w_out[4];
    assign p3  = w_out[3];
    assign p2  = w_out[2];
    assign p1  = w_out[1];
    assign p0  = w_out[0];
    assign any = |w_out;
    assign ovr = r_ovr;

endmodule

// File: tb/tb_req_latch_8.sv
// tb/tb_req_latch_8.sv - directed self-checking bench for req_latch_8 in edge and level mode

module tb_req_latch_8;

    logic       Clk;
    logic       Reset;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       ack;
    logic [2:0] ack_idx;
    logic       clr_ovr;

    logic e_p7, e_p6, e_p5, e_p4, e_p3, e_p2, e_p1, e_p0, e_any, e_ovr;
    logic l_p7, l_p6, l_p5, l_p4, l_p3, l_p2, l_p1, l_p0, l_any, l_ovr;
    logic [7:0] e_p;
    logic [7:0] l_p;

    int checks;
    int errors;

    assign e_p = {e_p7, e_p6, e_p5, e_p4, e_p3, e_p2, e_p1, e_p0};
    assign l_p = {l_p7, l_p6, l_p5, l_p4, l_p3, l_p2, l_p1, l_p0};

    req_latch_8 #(.EDGE_MODE(1)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack(ack), .ack_idx(ack_idx), .clr_ovr(clr_ovr),
        .p7(e_p7), .p6(e_p6), .p5(e_p5), .p4(e_p4), .p3(e_p3), .p2(e_p2), .p1(e_p1), .p0(e_p0),
        .any(e_any), .ovr(e_ovr)
    );

    req_latch_8 #(.EDGE_MODE(0)) dut_lvl (
        .Clk(Clk), .Reset(Reset), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack(ack), .ack_idx(ack_idx), .clr_ovr(clr_ovr),
        .p7(l_p7), .p6(l_p6), .p5(l_p5), .p4(l_p4), .p3(l_p3), .p2(l_p2), .p1(l_p1), .p0(l_p0),
        .any(l_any), .ovr(l_ovr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_ack(input logic [2:0] idx);
        ack = 1'b1;
        ack_idx = idx;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        req = 8'h10;
        tick();
        tick();
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL reset_p: got %h expected %h", e_p, 8'h00); end
        checks++; if (e_any !== 1'b0) begin errors++; $display("FAIL reset_any: got %b expected %b", e_any, 1'b0); end
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b expected %b", e_ovr, 1'b0); end
        checks++; if (l_p !== 8'h00) begin errors++; $display("FAIL reset_lvl_p: got %h expected %h", l_p, 8'h00); end
        Reset = 1'b0;
        tick();
        checks++; if (e_p !== 8'h10) begin errors++; $display("FAIL held_through_reset: got %h expected %h", e_p, 8'h10); end
        req = 8'h00;
        do_ack(3'd4);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL held_ack_p: got %h expected %h", e_p, 8'h00); end
        checks++; if (e_any !== 1'b0) begin errors++; $display("FAIL held_ack_any: got %b expected %b", e_any, 1'b0); end
    endtask

    task automatic test_basic_capture();
        req = 8'h20;
        tick();
        req = 8'h00;
        checks++; if (e_p !== 8'h20) begin errors++; $display("FAIL capture_p: got %h expected %h", e_p, 8'h20); end
        checks++; if (e_any !== 1'b1) begin errors++; $display("FAIL capture_any: got %b expected %b", e_any, 1'b1); end
        tick();
        tick();
        checks++; if (e_p !== 8'h20) begin errors++; $display("FAIL capture_sticky: got %h expected %h", e_p, 8'h20); end
        do_ack(3'd5);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL capture_clear: got %h expected %h", e_p, 8'h00); end
    endtask

    task automatic test_multi_ack();
        req = 8'h42;
        tick();
        req = 8'h00;
        checks++; if (e_p !== 8'h42) begin errors++; $display("FAIL multi_set: got %h expected %h", e_p, 8'h42); end
        do_ack(3'd6);
        checks++; if (e_p !== 8'h02) begin errors++; $display("FAIL multi_ack6_p: got %h expected %h", e_p, 8'h02); end
        checks++; if (e_any !== 1'b1) begin errors++; $display("FAIL multi_ack6_any: got %b expected %b", e_any, 1'b1); end
        do_ack(3'd1);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL multi_ack1_p: got %h expected %h", e_p, 8'h00); end
        checks++; if (e_any !== 1'b0) begin errors++; $display("FAIL multi_ack1_any: got %b expected %b", e_any, 1'b0); end
        do_ack(3'd3);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL ack_idle_p: got %h expected %h", e_p, 8'h00); end
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL ack_idle_ovr: got %b expected %b", e_ovr, 1'b0); end
    endtask

    task automatic test_simul_set_ack();
        req = 8'h08;
        tick();
        req = 8'h00;
        tick();
        req = 8'h08;
        do_ack(3'd3);
        req = 8'h00;
        checks++; if (e_p !== 8'h08) begin errors++; $display("FAIL simul_p3: got %h expected %h", e_p, 8'h08); end
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL simul_ovr: got %b expected %b", e_ovr, 1'b0); end
        do_ack(3'd3);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL simul_clear: got %h expected %h", e_p, 8'h00); end
    endtask

    task automatic test_mask();
        mask_wr = 1'b1;
        mask_in = 8'h7F;
        tick();
        mask_wr = 1'b0;
        req = 8'h80;
        tick();
        req = 8'h00;
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL mask_hidden_p: got %h expected %h", e_p, 8'h00); end
        checks++; if (e_any !== 1'b0) begin errors++; $display("FAIL mask_hidden_any: got %b expected %b", e_any, 1'b0); end
        mask_wr = 1'b1;
        mask_in = 8'hFF;
        tick();
        mask_wr = 1'b0;
        checks++; if (e_p !== 8'h80) begin errors++; $display("FAIL mask_reveal_p: got %h expected %h", e_p, 8'h80); end
        checks++; if (e_any !== 1'b1) begin errors++; $display("FAIL mask_reveal_any: got %b expected %b", e_any, 1'b1); end
        do_ack(3'd7);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL mask_clear: got %h expected %h", e_p, 8'h00); end
    endtask

    task automatic test_overrun();
        req = 8'h04;
        tick();
        req = 8'h00;
        tick();
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL ovr_first: got %b expected %b", e_ovr, 1'b0); end
        req = 8'h04;
        tick();
        req = 8'h00;
        checks++; if (e_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected %b", e_ovr, 1'b1); end
        checks++; if (e_p !== 8'h04) begin errors++; $display("FAIL ovr_p2: got %h expected %h", e_p, 8'h04); end
        tick();
        tick();
        checks++; if (e_ovr !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected %b", e_ovr, 1'b1); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected %b", e_ovr, 1'b0); end
        checks++; if (e_p !== 8'h04) begin errors++; $display("FAIL ovr_clear_keeps_p: got %h expected %h", e_p, 8'h04); end
        req = 8'h04;
        clr_ovr = 1'b1;
        tick();
        req = 8'h00;
        clr_ovr = 1'b0;
        checks++; if (e_ovr !== 1'b1) begin errors++; $display("FAIL ovr_set_beats_clr: got %b expected %b", e_ovr, 1'b1); end
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        do_ack(3'd2);
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL ovr_final: got %b expected %b", e_ovr, 1'b0); end
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL ovr_final_p: got %h expected %h", e_p, 8'h00); end
    endtask

    task automatic test_edge_vs_level();
        Reset = 1'b1;
        #1;
        checks++; if (e_p !== 8'h00 || l_p !== 8'h00) begin errors++; $display("FAIL async_reset: got %h/%h expected 00/00", e_p, l_p); end
        tick();
        Reset = 1'b0;
        req = 8'h01;
        tick();
        checks++; if (e_p !== 8'h01) begin errors++; $display("FAIL evl_edge_set: got %h expected %h", e_p, 8'h01); end
        checks++; if (l_p !== 8'h01) begin errors++; $display("FAIL evl_lvl_set: got %h expected %h", l_p, 8'h01); end
        tick();
        do_ack(3'd0);
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL evl_edge_acked: got %h expected %h", e_p, 8'h00); end
        checks++; if (l_p !== 8'h01) begin errors++; $display("FAIL evl_lvl_acked: got %h expected %h", l_p, 8'h01); end
        tick();
        checks++; if (e_p !== 8'h00) begin errors++; $display("FAIL evl_edge_stays: got %h expected %h", e_p, 8'h00); end
        checks++; if (l_p !== 8'h01) begin errors++; $display("FAIL evl_lvl_stays: got %h expected %h", l_p, 8'h01); end
        checks++; if (l_ovr !== 1'b1) begin errors++; $display("FAIL evl_lvl_ovr: got %b expected %b", l_ovr, 1'b1); end
        checks++; if (e_ovr !== 1'b0) begin errors++; $display("FAIL evl_edge_ovr: got %b expected %b", e_ovr, 1'b0); end
        req = 8'h00;
        tick();
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        Reset   = 1'b1;
        req     = 8'h00;
        mask_wr = 1'b0;
        mask_in = 8'h00;
        ack     = 1'b0;
        ack_idx = 3'd0;
        clr_ovr = 1'b0;

        test_reset();
        test_basic_capture();
        test_multi_ack();
        test_simul_set_ack();
        test_mask();
        test_overrun();
        test_edge_vs_level();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
